// File: rtl/restart_sequencer.sv
// Restart sequencer: arbitrates restart requests, pulses RESTART_ALL to the POR FSM,
// confirms the RUN drop/return, retries, and enforces a hold-off. Optional `LOCK_WDOG_EN adds a lock-loss watchdog.
module restart_sequencer #(
    parameter logic [15:0] HOLDOFF   = 16'd1000,
    parameter logic [4:0]  DROP_TMO  = 5'd16,
    parameter logic [23:0] RUN_TMO   = 24'hFFFFFF,
    parameter logic [1:0]  MAX_RETRY = 2'd3,
    parameter logic [15:0] LOCK_FLT  = 16'd255
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    input  logic [3:0] POR_STATE,
    input  logic       RUN,
    input  logic       QPLL_LOCK,
    input  logic       MMCM_LOCK,
    input  logic       CLR_STATUS,
    output logic       RESTART_ALL,
    output logic [3:0] ACK,
    output logic       BUSY,
    output logic       FAIL,
    output logic [2:0] CAUSE,
    output logic [7:0] RESTART_CNT
);

    localparam logic [3:0] RUN_STATE = 4'b0101;
    localparam logic [2:0] NO_CAUSE  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_W4DROP  = 3'd2,
        S_W4RUN   = 3'd3,
        S_HOLDOFF = 3'd4,
        S_FAILED  = 3'd5
    } state_t;

    state_t      state_r;
    logic [23:0] timer_r;
    logic [1:0]  retry_r;
    logic [4:0]  pending_r;
    logic [3:0]  req_d_r;
    logic [2:0]  grant_idx_s;
    logic [4:0]  grant_mask_s;
    logic        wdog_s;

    // Lowest set index wins; 7 means nothing pending.
    function automatic logic [2:0] lowest_idx(input logic [4:0] p);
        logic [2:0] idx;
        idx = 3'd7;
        for (int i = 4; i >= 0; i--) begin
            if (p[i]) idx = 3'(i);
            else      idx = idx;
        end
        return idx;
    endfunction

    // True on the last cycle of a state stay lasting lim cycles (timer is 0 on entry).
    function automatic logic reached(input logic [23:0] t, input logic [23:0] lim);
        return ({1'b0, t} + 25'd1) == {1'b0, lim};
    endfunction

    function automatic logic [3:0] ack_of(input logic [2:0] idx);
        return idx[2] ? 4'b0000 : (4'b0001 << idx[1:0]);
    endfunction

`ifdef LOCK_WDOG_EN
    logic [15:0] lock_cnt_r;

    // Watchdog fires on the cycle that completes LOCK_FLT consecutive lock-loss cycles.
    always_comb begin
        wdog_s = 1'b0;
        if (RUN && !(QPLL_LOCK && MMCM_LOCK) &&
            (({1'b0, lock_cnt_r} + 17'd1) == {1'b0, LOCK_FLT})) begin
            wdog_s = 1'b1;
        end else begin
            wdog_s = 1'b0;
        end
    end

    // Lock-loss run counter, only meaningful while the POR FSM is running.
    always_ff @(posedge CLK) begin
        if (RST || !RUN || (QPLL_LOCK && MMCM_LOCK) || wdog_s) begin
            lock_cnt_r <= 16'd0;
        end else begin
            lock_cnt_r <= lock_cnt_r + 16'd1;
        end
    end
`else
    logic unused_lock_s;
    assign unused_lock_s = QPLL_LOCK ^ MMCM_LOCK;
    assign wdog_s        = 1'b0;
`endif

    // Grant selection: only from IDLE while the POR FSM sits in its run state.
    always_comb begin
        grant_idx_s  = NO_CAUSE;
        grant_mask_s = 5'd0;
        if ((state_r == S_IDLE) && RUN && (POR_STATE == RUN_STATE)) begin
            grant_idx_s = lowest_idx(pending_r);
        end else begin
            grant_idx_s = NO_CAUSE;
        end
        if (grant_idx_s != NO_CAUSE) begin
            grant_mask_s = 5'b00001 << grant_idx_s;
        end else begin
            grant_mask_s = 5'd0;
        end
    end

    // Request edge capture and pending set; clear drops same-cycle edges.
    always_ff @(posedge CLK) begin
        if (RST) begin
            req_d_r   <= 4'd0;
            pending_r <= 5'd0;
        end else begin
            req_d_r <= REQ;
            if (CLR_STATUS) begin
                pending_r <= 5'd0;
            end else begin
                pending_r <= (pending_r & ~grant_mask_s) | {wdog_s, REQ & ~req_d_r};
            end
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge CLK) begin
        if (RST || CLR_STATUS) begin
            state_r     <= S_IDLE;
            timer_r     <= 24'd0;
            retry_r     <= 2'd0;
            RESTART_ALL <= 1'b0;
            ACK         <= 4'd0;
            BUSY        <= 1'b0;
            FAIL        <= 1'b0;
            CAUSE       <= NO_CAUSE;
            RESTART_CNT <= 8'd0;
        end else begin
            RESTART_ALL <= 1'b0;
            ACK         <= 4'd0;
            timer_r     <= (timer_r == 24'hFFFFFF) ? timer_r : timer_r + 24'd1;
            case (state_r)
                S_IDLE: begin
                    if (grant_idx_s != NO_CAUSE) begin
                        state_r     <= S_ISSUE;
                        timer_r     <= 24'd0;
                        retry_r     <= 2'd0;
                        CAUSE       <= grant_idx_s;
                        RESTART_ALL <= 1'b1;
                        ACK         <= ack_of(grant_idx_s);
                        BUSY        <= 1'b1;
                        RESTART_CNT <= (RESTART_CNT == 8'hFF) ? RESTART_CNT : RESTART_CNT + 8'd1;
                    end
                end
                S_ISSUE: begin
                    state_r <= S_W4DROP;
                    timer_r <= 24'd0;
                end
                S_W4DROP: begin
                    if (!RUN) begin
                        state_r <= S_W4RUN;
                        timer_r <= 24'd0;
                    end else if (reached(timer_r, {19'd0, DROP_TMO})) begin
                        timer_r <= 24'd0;
                        if (retry_r == MAX_RETRY) begin
                            state_r <= S_FAILED;
                            FAIL    <= 1'b1;
                            BUSY    <= 1'b0;
                        end else begin
                            // Re-issue without an ACK: the requester was already acknowledged.
                            state_r     <= S_ISSUE;
                            retry_r     <= retry_r + 2'd1;
                            RESTART_ALL <= 1'b1;
                            RESTART_CNT <= (RESTART_CNT == 8'hFF) ? RESTART_CNT : RESTART_CNT + 8'd1;
                        end
                    end
                end
                S_W4RUN: begin
                    if (RUN && (POR_STATE == RUN_STATE)) begin
                        state_r <= S_HOLDOFF;
                        timer_r <= 24'd0;
                    end else if (reached(timer_r, RUN_TMO)) begin
                        state_r <= S_FAILED;
                        timer_r <= 24'd0;
                        FAIL    <= 1'b1;
                        BUSY    <= 1'b0;
                    end
                end
                S_HOLDOFF: begin
                    if (reached(timer_r, {8'd0, HOLDOFF})) begin
                        state_r <= S_IDLE;
                        timer_r <= 24'd0;
                        BUSY    <= 1'b0;
                    end
                end
                S_FAILED: begin
                    FAIL <= 1'b1;
                    BUSY <= 1'b0;
                end
                default: begin
                    state_r <= S_IDLE;
                    timer_r <= 24'd0;
                    BUSY    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restart_sequencer.sv
// Scoreboard bench for restart_sequencer with a behavioural POR FSM emulator.
module tb_restart_sequencer;

    localparam int HOLDOFF_CYC = 1000;
    localparam int RETRY_GAP   = 17;

    logic       CLK, RST, RUN, QPLL_LOCK, MMCM_LOCK, CLR_STATUS;
    logic [3:0] REQ, POR_STATE;
    logic       RESTART_ALL, BUSY, FAIL;
    logic [3:0] ACK;
    logic [2:0] CAUSE;
    logic [7:0] RESTART_CNT;

    restart_sequencer dut (
        .CLK(CLK), .RST(RST), .REQ(REQ), .POR_STATE(POR_STATE), .RUN(RUN),
        .QPLL_LOCK(QPLL_LOCK), .MMCM_LOCK(MMCM_LOCK), .CLR_STATUS(CLR_STATUS),
        .RESTART_ALL(RESTART_ALL), .ACK(ACK), .BUSY(BUSY), .FAIL(FAIL),
        .CAUSE(CAUSE), .RESTART_CNT(RESTART_CNT)
    );

    typedef struct {
        logic [3:0] ack;
        int         cause;
        int         gap;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0, failures = 0;
    int   cyc = 0;
    int   por_mode = 0;     // 0 normal, 1 stuck running, 2 held down, 3 drop and stay down
    int   ret_cyc = 0, ret_seq = 0, rise_cyc = 0;
    int   last_pulse = 0, pulses = 0, pushed = 0;
    int   model_cnt = 0, last_cause = 7;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic [3:0] ack, input int cause, input int gap, input int lat);
        exp_t e;
        e.ack = ack; e.cause = cause; e.gap = gap; e.lat = lat;
        exp_q.push_back(e);
        pushed++;
        if (model_cnt < 255) model_cnt++;
        last_cause = cause;
    endtask

    // Drive a one-cycle request mask; when granted, grants go out in ascending index order.
    task automatic pulse_req(input logic [3:0] m, input bit expect_grant);
        bit first = 1'b1;
        bit idle  = (BUSY === 1'b0) && (exp_q.size() == 0) && (RUN === 1'b1);
        for (int i = 0; i < 4; i++) begin
            if (m[i] && expect_grant) begin
                push_exp(4'b0001 << i, i, 0, (idle && first) ? cyc : -1);
                first = 1'b0;
            end
        end
        REQ = m;
        @(negedge CLK);
        REQ = 4'b0000;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (!(exp_q.size() == 0 && BUSY === 1'b0) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("idle_reached", (exp_q.size() == 0 && BUSY === 1'b0), 1);
    endtask

    task automatic wait_drained(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("queue_drained_in_time", exp_q.size(), 0);
    endtask

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
        end
    end

    // POR FSM emulator: drops RUN a few cycles after each RESTART_ALL, then returns it.
    initial begin
        int phase = 0, cnt = 0;
        RUN = 1'b1;
        POR_STATE = 4'd5;
        forever begin
            @(posedge CLK);
            #1;
            if (por_mode == 2) begin
                RUN = 1'b0; POR_STATE = 4'd5; phase = 0;
            end else if (por_mode == 1) begin
                RUN = 1'b1; POR_STATE = 4'd5; phase = 0;
            end else begin
                case (phase)
                    0: begin
                        if (!RUN) begin
                            RUN = 1'b1; POR_STATE = 4'd5; rise_cyc = cyc;
                        end else if (RESTART_ALL === 1'b1) begin
                            phase = 1; cnt = $urandom_range(8, 1);
                        end
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            RUN = 1'b0; POR_STATE = 4'd2;
                            cnt = $urandom_range(60, 5);
                            phase = (por_mode == 3) ? 3 : 2;
                        end
                    end
                    2: begin
                        cnt--;
                        if (cnt == 0) begin
                            RUN = 1'b1; POR_STATE = 4'd5;
                            ret_cyc = cyc + 1; ret_seq++;
                            phase = 0;
                        end
                    end
                    default: begin
                        if (por_mode == 0) begin
                            RUN = 1'b1; POR_STATE = 4'd5; rise_cyc = cyc; phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    // Monitor: pops the scoreboard on every RESTART_ALL and checks hold-off length.
    initial begin
        exp_t e;
        bit   busy_prev = 1'b0, prev_ra = 1'b0;
        int   ret_seen = 0;
        forever begin
            @(negedge CLK);
            if (RESTART_ALL === 1'b1) begin
                chk("restart_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("ack", ACK, e.ack);
                    chk("cause", CAUSE, e.cause);
                    if (e.gap > 0) chk("retry_gap", cyc - last_pulse, e.gap);
                    if (e.lat >= 0) chk("req_latency", cyc - e.lat, 2);
                end
                chk("pulse_width", prev_ra, 0);
                last_pulse = cyc;
                pulses++;
            end else if (ACK !== 4'b0000) begin
                chk("ack_without_restart", ACK, 0);
            end
            if (busy_prev && BUSY === 1'b0 && ret_seen != ret_seq) begin
                chk("holdoff_len", cyc - ret_cyc, HOLDOFF_CYC);
                ret_seen = ret_seq;
            end
            busy_prev = (BUSY === 1'b1);
            prev_ra   = (RESTART_ALL === 1'b1);
        end
    end

    initial begin
        int b, c;
        logic [3:0] m;
        RST = 1'b1; REQ = 4'b0010; CLR_STATUS = 1'b0; QPLL_LOCK = 1'b1; MMCM_LOCK = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_restart", RESTART_ALL, 0);
        chk("rst_ack", ACK, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_fail", FAIL, 0);
        chk("rst_cause", CAUSE, 7);
        chk("rst_cnt", RESTART_CNT, 0);

        // REQ[1] held through reset registers exactly one request.
        push_exp(4'b0010, 1, 0, cyc);
        RST = 1'b0;
        repeat (5) @(negedge CLK);
        REQ = 4'b0000;
        wait_idle(3000);
        chk("held_req_cnt", RESTART_CNT, model_cnt);

        // Random request masks, sometimes issued while a sequence is still in hold-off.
        for (int it = 0; it < 6; it++) begin
            if (it == 0 || $urandom_range(1, 0) == 1) wait_idle(6000);
            else wait_drained(6000);
            repeat ($urandom_range(20, 1)) @(negedge CLK);
            m = 4'($urandom_range(15, 1));
            pulse_req(m, 1'b1);
        end
        wait_idle(6000);
        chk("rand_cnt", RESTART_CNT, model_cnt);
        chk("rand_cause", CAUSE, last_cause);

        // POR FSM never drops RUN: initial pulse plus MAX_RETRY re-issues, then FAIL.
        por_mode = 1;
        @(negedge CLK);
        b = $urandom_range(3, 0);
        pulse_req(4'b0001 << b, 1'b1);
        for (int r = 0; r < 3; r++) push_exp(4'b0000, b, RETRY_GAP, -1);
        wait_idle(300);
        repeat (5) @(negedge CLK);
        chk("retry_fail", FAIL, 1);
        chk("retry_busy", BUSY, 0);
        chk("retry_cnt", RESTART_CNT, model_cnt);
        pulse_req(4'b0001 << $urandom_range(3, 0), 1'b0);
        repeat (3) @(negedge CLK);
        CLR_STATUS = 1'b1;
        @(negedge CLK);
        CLR_STATUS = 1'b0;
        model_cnt = 0; last_cause = 7;
        chk("clr_fail", FAIL, 0);
        chk("clr_cnt", RESTART_CNT, 0);
        chk("clr_cause", CAUSE, 7);
        por_mode = 0;
        repeat (40) @(negedge CLK);

        // Requests wait while the POR FSM is not running.
        por_mode = 2;
        repeat (3) @(negedge CLK);
        pulse_req(4'b0001, 1'b1);
        repeat (30) @(negedge CLK);
        chk("gate_held", exp_q.size(), 1);
        chk("gate_busy", BUSY, 0);
        por_mode = 0;
        wait_idle(3000);
        chk("gate_latency_ok", (last_pulse - rise_cyc >= 1) && (last_pulse - rise_cyc <= 2), 1);

        // Lock loss for just over LOCK_FLT cycles.
`ifdef LOCK_WDOG_EN
        push_exp(4'b0000, 4, 0, -1);
`endif
        QPLL_LOCK = 1'b0;
        repeat (260) @(negedge CLK);
        QPLL_LOCK = 1'b1;
        repeat (5) @(negedge CLK);
        wait_idle(3000);
        chk("wdog_cnt", RESTART_CNT, model_cnt);
        chk("wdog_cause", CAUSE, last_cause);

        // Synchronous reset in W4RUN discards the sequence and pending requests.
        por_mode = 3;
        b = $urandom_range(3, 0);
        c = (b + 1) % 4;
        pulse_req(4'b0001 << b, 1'b1);
        wait_drained(100);
        repeat (30) @(negedge CLK);
        pulse_req(4'b0001 << c, 1'b0);
        repeat (3) @(negedge CLK);
        chk("w4run_busy", BUSY, 1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        model_cnt = 0; last_cause = 7;
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_cause", CAUSE, 7);
        chk("mid_rst_cnt", RESTART_CNT, 0);
        chk("mid_rst_restart", RESTART_ALL, 0);
        por_mode = 0;
        repeat (60) @(negedge CLK);

        chk("scoreboard_empty", exp_q.size(), 0);
        chk("pulse_total", pulses, pushed);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/restart_sequencer.md
# restart_sequencer

Schedules and issues RESTART_ALL to the triplicated power-on-reset FSM on behalf of up to four restart requesters: JTAG command, SEU monitor, ODMB hard reset, spare. Arbitrates simultaneous requests by fixed priority. Confirms that the POR FSM leaves and re-enters its run state, retries or flags failure, and enforces a hold-off between restarts. Sits beside the POR FSM in the DCFEB top level and consumes its RUN and POR_STATE outputs.

## Interface
- HOLDOFF, 16'd1000: cycles after RUN returns before the next request may be granted.
- DROP_TMO, 5'd16: cycles to wait for RUN to fall after a RESTART_ALL pulse.
- RUN_TMO, 24'hFFFFFF: cycles to wait for RUN to return after it falls.
- MAX_RETRY, 2'd3: RESTART_ALL re-issues allowed per grant.
- LOCK_FLT, 16'd255: consecutive lock-loss cycles that raise a watchdog request (LOCK_WDOG_EN only).
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ  in  4  restart requests, rising-edge sensitive; bit 0 has highest priority.
- POR_STATE  in  4  POR FSM state; 4'b0101 = run state.
- RUN  in  1  POR FSM run flag.
- QPLL_LOCK  in  1  QPLL lock.
- MMCM_LOCK  in  1  MMCM lock.
- CLR_STATUS  in  1  clears FAIL, RESTART_CNT, CAUSE and pending requests.
- RESTART_ALL  out  1  one-cycle restart pulse to the POR FSM.
- ACK  out  4  one-cycle grant pulse per requester.
- BUSY  out  1  restart sequence in progress.
- FAIL  out  1  sticky; restart not completed.
- CAUSE  out  3  source of the last grant: 0–3 = REQ index, 4 = watchdog, 7 = none.
- RESTART_CNT  out  8  RESTART_ALL pulses issued, saturating at 255.

## Operation
- Reset values: RESTART_ALL=0, ACK=0, BUSY=0, FAIL=0, CAUSE=7, RESTART_CNT=0, pending=0, REQ history=0, state IDLE. A REQ bit held high through reset therefore registers one request.
- Pending set: pending_next = (pending & ~grant) | (REQ & ~REQ_d) | wdog. Requests latch in every state, including FAILED. A new edge on the same cycle as that bit's grant re-sets the bit.
- IDLE:
  - Grant only when pending≠0, RUN=1 and POR_STATE=4'b0101.
  - Grant the lowest set index: load CAUSE, clear that pending bit, clear the retry count, go to ISSUE.
  - While RUN=0, requests stay pending.
- ISSUE: RESTART_ALL=1 and ACK[CAUSE]=1 for exactly this cycle; RESTART_CNT+1 (saturating). On a retry, ACK stays 0. Next state is W4DROP with the timer cleared.
- W4DROP:
  - RUN=0 → W4RUN with the timer cleared.
  - Timer reaches DROP_TMO → retry count+1 and go to ISSUE. If the count is already MAX_RETRY, go to FAILED instead.
- W4RUN:
  - RUN=1 and POR_STATE=4'b0101 → HOLDOFF with the timer cleared.
  - Timer reaches RUN_TMO → FAILED.
- HOLDOFF: timer reaches HOLDOFF → IDLE.
- FAILED: FAIL=1 and held. Left only via CLR_STATUS or RST.
- BUSY=1 in ISSUE, W4DROP, W4RUN and HOLDOFF.
- CLR_STATUS, any state:
  - Next cycle: FAIL=0, RESTART_CNT=0, CAUSE=7, pending=0, state IDLE.
  - It takes priority over a same-cycle grant, and REQ edges in that cycle are discarded.
- Single shared timer, 24 bits, cleared on every state entry, saturating.

## Timing
- Grant decision in IDLE at edge t; RESTART_ALL and ACK are high in cycle t+1 only (registered outputs).
- Minimum REQ-edge-to-RESTART_ALL latency: 2 cycles (edge capture, then grant).
- Minimum spacing between restarts from separate grants: 1 (ISSUE) + drop + return + HOLDOFF cycles.
- A synchronous RST mid-sequence forces IDLE at the next edge; RESTART_ALL is low from that edge.

## Configuration
- LOCK_WDOG_EN defined:
  - While RUN=1, a 16-bit counter increments on each cycle with QPLL_LOCK=0 or MMCM_LOCK=0, and clears on any cycle with both locked or with RUN=0.
  - Reaching LOCK_FLT sets pending bit 4 (lowest priority, CAUSE=4) once and clears the counter.
- LOCK_WDOG_EN undefined: QPLL_LOCK and MMCM_LOCK are unused, pending bit 4 is never set, and CAUSE never equals 4.

## Test plan
- Basic restart: RUN=1, POR_STATE=5, REQ[2] pulses at t → RESTART_ALL and ACK[2] high at t+2 only; CAUSE=2; RESTART_CNT=1; RUN falls 3 cycles later and returns 200 cycles later → BUSY falls 1000 cycles after the return.
- Priority and pending: REQ[3] and REQ[1] rise together → REQ[1] granted (CAUSE=1); REQ[3] granted after the hold-off expires (CAUSE=3, RESTART_CNT=2).
- Retry exhaustion: RUN held at 1 → 4 RESTART_ALL pulses spaced 17 cycles apart, a single ACK, then FAIL=1, RESTART_CNT=4; CLR_STATUS → FAIL=0, CNT=0, CAUSE=7.
- Not-running gate: RUN=0, REQ[0] pulses → no RESTART_ALL; RUN rises with POR_STATE=5 → RESTART_ALL 2 cycles later.
- Watchdog (LOCK_WDOG_EN): RUN=1, QPLL_LOCK=0 for 255 cycles → CAUSE=4, RESTART_ALL pulses, no ACK bit set; with the macro undefined → no pulse.
- RST asserted in W4RUN → next cycle BUSY=0, CAUSE=7, RESTART_CNT=0, and pending requests are lost.
